// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, NOP encoding,
// reset address, FSM state encoding and the buffered fetch entry layout.
package inst_fetch_pkg;

   localparam int InstBus     = 32;
   localparam int InstAddrBus = 32;

   localparam logic [InstBus-1:0]     INST_NOP = 32'h0000_0013;
   localparam logic [InstAddrBus-1:0] RST_ADDR = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [InstAddrBus-1:0] addr;
      logic [InstBus-1:0]     inst;
   } fetch_entry_t;

   // Word-aligned redirect target for builds that do not report misalignment.
   function automatic logic [InstAddrBus-1:0] align_word(input logic [InstAddrBus-1:0] a);
      return {a[InstAddrBus-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
interface inst_fetch_if;
   import inst_fetch_pkg::*;

   logic                   ibus_req_o;
   logic [InstAddrBus-1:0] ibus_addr_o;
   logic                   ibus_ack_i;
   logic [InstBus-1:0]     ibus_rdata_i;

   modport master (
      output ibus_req_o,
      output ibus_addr_o,
      input  ibus_ack_i,
      input  ibus_rdata_i
   );

   modport slave (
      input  ibus_req_o,
      input  ibus_addr_o,
      output ibus_ack_i,
      output ibus_rdata_i
   );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry FIFO with flush; head is presented combinationally on dout_o.
module inst_fetch_fifo #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic [1:0]       count_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic             wr_ptr_q;
   logic             rd_ptr_q;
   logic [1:0]       count_q;
   logic             do_push;
   logic             do_pop;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   assign do_pop  = pop_i & (count_q != 2'd0);
   assign do_push = push_i & ((count_q != 2'd2) | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (do_push) wr_ptr_q <= ~wr_ptr_q;
         if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == 2'd0);
   assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC + request FSM feeding a 2-entry instruction buffer.
// Optional INST_FETCH_MISALIGN_EN flags misaligned redirects and stalls fetch.
module inst_fetch
   import inst_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   inst_fetch_if.master           ibus,
   input  logic                   jump_flag_i,
   input  logic [InstAddrBus-1:0] jump_addr_i,
   input  logic                   id_ready_i,
   output logic                   inst_valid_o,
   output logic [InstBus-1:0]     inst_o,
   output logic [InstAddrBus-1:0] inst_addr_o
`ifdef INST_FETCH_MISALIGN_EN
   ,
   output logic                   fetch_misalign_o
`endif
);

   fetch_state_e           state_q;
   logic [InstAddrBus-1:0] fetch_pc_q;
   logic [InstAddrBus-1:0] addr_q;
   logic                   req_q;

   logic [InstAddrBus-1:0] jump_tgt;
   logic [InstAddrBus-1:0] pc_inc;
   logic                   fetch_en;
   logic                   ack;
   logic                   push;
   logic                   pop;
   logic                   fifo_empty;
   logic [1:0]             fifo_count;
   logic [1:0]             cnt_after;
   fetch_entry_t           head;

`ifdef INST_FETCH_MISALIGN_EN
   logic misalign_q;

   assign jump_tgt = jump_addr_i;
   assign fetch_en = ~misalign_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              misalign_q <= 1'b0;
      else if (jump_flag_i) misalign_q <= (jump_addr_i[1:0] != 2'b00);
   end

   assign fetch_misalign_o = misalign_q;
`else
   logic unused_jump_lsb;

   assign unused_jump_lsb = ^jump_addr_i[1:0];
   assign jump_tgt        = align_word(jump_addr_i);
   assign fetch_en        = 1'b1;
`endif

   assign ack       = ibus.ibus_ack_i;
   assign pc_inc    = fetch_pc_q + 32'd4;
   assign push      = (state_q == REQ) & ack & ~jump_flag_i;
   assign pop       = ~fifo_empty & id_ready_i & ~jump_flag_i;
   assign cnt_after = fifo_count + 2'd1 - {1'b0, pop};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RST_ADDR;
         addr_q     <= RST_ADDR;
         req_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_tgt;
               end else if (fetch_en && (fifo_count < 2'd2)) begin
                  req_q   <= 1'b1;
                  addr_q  <= fetch_pc_q;
                  state_q <= REQ;
               end
            end
            REQ: begin
               if (jump_flag_i) begin
                  fetch_pc_q <= jump_tgt;
                  if (ack) begin
                     req_q   <= 1'b0;
                     state_q <= IDLE;
                  end else begin
                     state_q <= DROP;
                  end
               end else if (ack) begin
                  // Chain the next request directly when the buffer still has room.
                  fetch_pc_q <= pc_inc;
                  if (cnt_after < 2'd2) begin
                     addr_q <= pc_inc;
                  end else begin
                     req_q   <= 1'b0;
                     state_q <= IDLE;
                  end
               end
            end
            DROP: begin
               if (jump_flag_i) fetch_pc_q <= jump_tgt;
               if (ack) begin
                  req_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   inst_fetch_fifo #(
      .WIDTH($bits(fetch_entry_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (jump_flag_i),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({fetch_pc_q, ibus.ibus_rdata_i}),
      .dout_o  (head),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ibus.ibus_req_o  = req_q;
   assign ibus.ibus_addr_o = addr_q;

   assign inst_valid_o = ~fifo_empty;
   assign inst_o       = fifo_empty ? INST_NOP : head.inst;
   assign inst_addr_o  = fifo_empty ? '0 : head.addr;

endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: table-driven phases plus hand-written redirect,
// reset, wrap and INST_FETCH_MISALIGN_EN sequences, all backed by a scoreboard.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] inst;
   } sb_t;

   typedef struct {
      int          cycles;
      logic        ready;
      int          lat;
      logic        exp_valid;
      logic        exp_req;
      logic [31:0] exp_head;
   } phase_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        jump_flag_i = 1'b0;
   logic [31:0] jump_addr_i = 32'h0;
   logic        id_ready_i = 1'b0;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
`ifdef INST_FETCH_MISALIGN_EN
   logic        fetch_misalign_o;
`endif

   inst_fetch_if ifc ();

   inst_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .ibus         (ifc),
      .jump_flag_i  (jump_flag_i),
      .jump_addr_i  (jump_addr_i),
      .id_ready_i   (id_ready_i),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o)
`ifdef INST_FETCH_MISALIGN_EN
      ,
      .fetch_misalign_o (fetch_misalign_o)
`endif
   );

   always #5 clk = ~clk;

   int          n_pass = 0;
   int          n_total = 0;
   int          ack_lat = 0;
   int          wait_cnt = 0;
   logic        drop_pend = 1'b0;
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] last_pop = 32'h0;
   logic        saw_wrap = 1'b0;
   sb_t         exp_q [$];
   phase_t      tbl [7];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h0000_5A5A;
   endfunction

   function automatic logic [31:0] jmp_target(input logic [31:0] a);
`ifdef INST_FETCH_MISALIGN_EN
      return a;
`else
      return {a[31:2], 2'b00};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
   endtask

   task automatic sb_reset();
      exp_q.delete();
      exp_pc    = 32'h0;
      drop_pend = 1'b0;
      wait_cnt  = 0;
   endtask

   // One clock: memory responder, scoreboard bookkeeping and output checks at negedge.
   task automatic step();
      logic ack;
      logic req_s;
      sb_t  e;
      req_s = ifc.ibus_req_o;
      ack   = req_s && (wait_cnt >= ack_lat);
      ifc.ibus_ack_i   = ack;
      ifc.ibus_rdata_i = ack ? mem_word(ifc.ibus_addr_o) : 32'hDEAD_BEEF;
      if (inst_valid_o) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 32'(exp_q.size()), 32'd1);
         end else begin
            check("sb_addr", inst_addr_o, exp_q[0].addr);
            check("sb_inst", inst_o, exp_q[0].inst);
            if (id_ready_i && !jump_flag_i) begin
               if (exp_q[0].addr == 32'h0 && last_pop == 32'hFFFF_FFFC) saw_wrap = 1'b1;
               last_pop = exp_q[0].addr;
               void'(exp_q.pop_front());
            end
         end
      end else begin
         check("idle_inst_nop", inst_o, INST_NOP);
         check("idle_addr_zero", inst_addr_o, 32'h0);
      end
      if (jump_flag_i) begin
         exp_q.delete();
         exp_pc    = jmp_target(jump_addr_i);
         drop_pend = req_s && !ack;
      end else if (ack) begin
         if (drop_pend) begin
            drop_pend = 1'b0;
         end else begin
            check("ack_addr", ifc.ibus_addr_o, exp_pc);
            e.addr = exp_pc;
            e.inst = mem_word(exp_pc);
            exp_q.push_back(e);
            exp_pc = exp_pc + 32'd4;
         end
      end
      $display("cyc t=%0t req=%0b addr=%08h ack=%0b jump=%0b rdy=%0b valid=%0b inst_addr=%08h inst=%08h",
               $time, req_s, ifc.ibus_addr_o, ack, jump_flag_i, id_ready_i,
               inst_valid_o, inst_addr_o, inst_o);
      @(posedge clk);
      wait_cnt = (req_s && !ack) ? wait_cnt + 1 : 0;
      #1 ifc.ibus_ack_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic jump_step(input logic [31:0] tgt);
      jump_flag_i = 1'b1;
      jump_addr_i = tgt;
      step();
      jump_flag_i = 1'b0;
   endtask

   initial begin
      tbl[0] = '{5, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0000};
      tbl[1] = '{1, 1'b1, 0, 1'b1, 1'b0, 32'h0000_0004};
      tbl[2] = '{1, 1'b0, 0, 1'b1, 1'b1, 32'h0000_0004};
      tbl[3] = '{3, 1'b0, 0, 1'b1, 1'b0, 32'h0000_0004};
      tbl[4] = '{2, 1'b1, 0, 1'b0, 1'b1, 32'h0000_0000};
      tbl[5] = '{4, 1'b1, 0, 1'b1, 1'b1, 32'h0000_0018};
      tbl[6] = '{6, 1'b1, 2, 1'b1, 1'b1, 32'h0000_0020};

      ifc.ibus_ack_i   = 1'b0;
      ifc.ibus_rdata_i = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_req", {31'b0, ifc.ibus_req_o}, 32'h0);
      check("rst_addr", ifc.ibus_addr_o, 32'h0);
      check("rst_valid", {31'b0, inst_valid_o}, 32'h0);
      check("rst_inst", inst_o, INST_NOP);
      check("rst_inst_addr", inst_addr_o, 32'h0);
`ifdef INST_FETCH_MISALIGN_EN
      check("rst_misalign", {31'b0, fetch_misalign_o}, 32'h0);
`endif
      rst = 1'b0;

      // Back-pressure, refill and throughput phases from reset.
      for (int r = 0; r < 7; r++) begin
         id_ready_i = tbl[r].ready;
         ack_lat    = tbl[r].lat;
         repeat (tbl[r].cycles) step();
         check($sformatf("row%0d_valid", r), {31'b0, inst_valid_o}, {31'b0, tbl[r].exp_valid});
         check($sformatf("row%0d_req", r), {31'b0, ifc.ibus_req_o}, {31'b0, tbl[r].exp_req});
         check($sformatf("row%0d_head", r), inst_addr_o, tbl[r].exp_head);
      end

      // Reset asserted while a request is outstanding.
      ack_lat = 10;
      step();
      step();
      check("pre_rst_req", {31'b0, ifc.ibus_req_o}, 32'h1);
      #2 rst = 1'b1;
      #1;
      check("async_rst_req", {31'b0, ifc.ibus_req_o}, 32'h0);
      check("async_rst_addr", ifc.ibus_addr_o, 32'h0);
      check("async_rst_valid", {31'b0, inst_valid_o}, 32'h0);
      check("async_rst_inst", inst_o, INST_NOP);
      sb_reset();
      @(negedge clk);
      rst = 1'b0;
      ack_lat = 0;
      id_ready_i = 1'b1;
      step();
      check("first_req", {31'b0, ifc.ibus_req_o}, 32'h1);
      check("first_req_addr", ifc.ibus_addr_o, 32'h0);

      // Redirect while the request at 0x8 is pending; its ack arrives later.
      step();
      step();
      check("pend_addr", ifc.ibus_addr_o, 32'h8);
      ack_lat = 3;
      jump_step(32'h0000_0100);
      check("drop_req_held", {31'b0, ifc.ibus_req_o}, 32'h1);
      check("drop_addr_held", ifc.ibus_addr_o, 32'h8);
      check("drop_flushed", {31'b0, inst_valid_o}, 32'h0);
      repeat (3) step();
      check("drop_done_req", {31'b0, ifc.ibus_req_o}, 32'h0);
      check("drop_done_valid", {31'b0, inst_valid_o}, 32'h0);
      step();
      check("redir_req", {31'b0, ifc.ibus_req_o}, 32'h1);
      check("redir_addr", ifc.ibus_addr_o, 32'h100);
      ack_lat = 0;
      step();
      check("redir_first_valid", {31'b0, inst_valid_o}, 32'h1);
      check("redir_first_addr", inst_addr_o, 32'h100);

      // Redirect coincident with ack and pop.
      jump_step(32'h0000_0300);
      check("jack_valid", {31'b0, inst_valid_o}, 32'h0);
      check("jack_inst", inst_o, INST_NOP);
      check("jack_req", {31'b0, ifc.ibus_req_o}, 32'h0);
      step();
      check("jack_next_addr", ifc.ibus_addr_o, 32'h300);
      repeat (3) step();

`ifdef INST_FETCH_MISALIGN_EN
      jump_step(32'h0000_0102);
      check("mis_set", {31'b0, fetch_misalign_o}, 32'h1);
      check("mis_req_low", {31'b0, ifc.ibus_req_o}, 32'h0);
      repeat (3) step();
      check("mis_stall_req", {31'b0, ifc.ibus_req_o}, 32'h0);
      check("mis_sticky", {31'b0, fetch_misalign_o}, 32'h1);
      jump_step(32'h0000_0200);
      check("mis_clear", {31'b0, fetch_misalign_o}, 32'h0);
      step();
      check("mis_resume_req", {31'b0, ifc.ibus_req_o}, 32'h1);
      check("mis_resume_addr", ifc.ibus_addr_o, 32'h200);
      repeat (3) step();
`else
      jump_step(32'h0000_0102);
      step();
      check("lsb_mask_req", {31'b0, ifc.ibus_req_o}, 32'h1);
      check("lsb_mask_addr", ifc.ibus_addr_o, 32'h100);
      repeat (3) step();
`endif

      // PC wrap-around at the top of the address space.
      jump_step(32'hFFFF_FFF8);
      repeat (8) step();
      check("pc_wrap_seen", {31'b0, saw_wrap}, 32'h1);

      repeat (4) step();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
